// File: rtl/glb_ifmap_reader.sv
// rtl/glb_ifmap_reader.sv - streams one GLB ifmap tile as tagged elements (row/col/ch) through a 2-entry FIFO
// Optional GLB_RD_PERF_EN adds the stall_cycles output-backpressure counter.
module glb_ifmap_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    done,
    output logic                    busy,
    input  logic [31:0]             mapping_param,
    input  logic [31:0]             shape_param1,
    input  logic [31:0]             shape_param2,
    input  logic [31:0]             row_start,
    input  logic [ADDR_WIDTH-1:0]   glb_ifmap_base_addr,
    output logic [ADDR_WIDTH-1:0]   glb_r_addr,
    input  logic [DATA_WIDTH*4-1:0] glb_r_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [31:0]             out_row,
    output logic [31:0]             out_col,
    output logic [31:0]             out_ch,
    output logic                    out_last
`ifdef GLB_RD_PERF_EN
    ,
    output logic [31:0]             stall_cycles
`endif
);
    localparam int EW = DATA_WIDTH + 97;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [31:0]           r_w, r_ct, r_row_end, r_row, r_col, r_ch;
    logic                  r_empty;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inf_valid, r_inf_last;
    logic [31:0]           r_inf_row, r_inf_col, r_inf_ch;
    logic [EW-1:0]         r_fifo [2];
    logic                  r_rd_ptr, r_wr_ptr;
    logic [1:0]            r_count;

    logic [5:0]            w_ct6;
    logic [31:0]           w_e, w_in_w, w_in_ct, w_in_row_end, w_in_off;
    logic                  w_accept, w_pop, w_room, w_issue, w_last_coord;
    logic [EW-1:0]         w_head;
    logic                  w_unused;

    assign w_ct6        = {3'd0, mapping_param[8:6]} * {3'd0, mapping_param[5:3]};
    assign w_e          = {28'd0, mapping_param[15:12]};
    assign w_in_ct      = {26'd0, w_ct6};
    assign w_in_w       = {24'd0, shape_param2[15:8]} + {28'd0, shape_param1[28:26], 1'b0};
    assign w_in_row_end = row_start + (w_e - 32'd1) * {30'd0, shape_param1[25:24]}
                          + {30'd0, shape_param1[23:22]} - 32'd1;
    assign w_in_off     = row_start * w_in_w * w_in_ct;

    assign w_unused = ^{mapping_param[31:16], mapping_param[11:9], mapping_param[2:0],
                        shape_param1[31:29], shape_param1[21:0], shape_param2[31:16],
                        shape_param2[7:0], glb_r_data[DATA_WIDTH*4-1:DATA_WIDTH]};

    // Traversal is contiguous in GLB, so the read address is just a running pointer.
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_pop        = out_valid && out_ready;
    assign w_room       = ({1'b0, r_count} + {2'b0, r_inf_valid} - {2'b0, w_pop}) < 3'd2;
    assign w_issue      = (r_state == S_ISSUE) && !r_empty && w_room;
    assign w_last_coord = (r_ch == r_ct - 32'd1) && (r_col == r_w - 32'd1) && (r_row == r_row_end);

    assign glb_r_addr = w_issue ? r_addr : '0;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    assign w_head    = r_fifo[r_rd_ptr];
    assign out_valid = (r_count != 2'd0);
    assign out_last  = w_head[EW-1];
    assign out_row   = w_head[DATA_WIDTH+95 -: 32];
    assign out_col   = w_head[DATA_WIDTH+63 -: 32];
    assign out_ch    = w_head[DATA_WIDTH+31 -: 32];
    assign out_data  = w_head[DATA_WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (r_empty)
                    w_state_nxt = S_DONE;
                else if (w_issue && w_last_coord)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if ((r_count - {1'b0, w_pop}) == 2'd0 && !r_inf_valid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_ct        <= '0;
            r_row_end   <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_ch        <= '0;
            r_empty     <= 1'b0;
            r_addr      <= '0;
            r_inf_valid <= 1'b0;
            r_inf_last  <= 1'b0;
            r_inf_row   <= '0;
            r_inf_col   <= '0;
            r_inf_ch    <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_w       <= w_in_w;
                r_ct      <= w_in_ct;
                r_row_end <= w_in_row_end;
                r_empty   <= (w_in_ct == 32'd0) || (w_e == 32'd0) || (w_in_w == 32'd0);
                r_row     <= row_start;
                r_col     <= '0;
                r_ch      <= '0;
                r_addr    <= glb_ifmap_base_addr + ADDR_WIDTH'(w_in_off);
            end
            if (w_issue) begin
                r_addr     <= r_addr + ADDR_WIDTH'(1);
                r_inf_row  <= r_row;
                r_inf_col  <= r_col;
                r_inf_ch   <= r_ch;
                r_inf_last <= w_last_coord;
                if (r_ch == r_ct - 32'd1) begin
                    r_ch <= '0;
                    if (r_col == r_w - 32'd1) begin
                        r_col <= '0;
                        r_row <= r_row + 32'd1;
                    end else begin
                        r_col <= r_col + 32'd1;
                    end
                end else begin
                    r_ch <= r_ch + 32'd1;
                end
            end
            r_inf_valid <= w_issue;
            // Read data lands one cycle after the address, alongside its pipelined tags.
            if (r_inf_valid) begin
                r_fifo[r_wr_ptr] <= {r_inf_last, r_inf_row, r_inf_col, r_inf_ch,
                                     glb_r_data[DATA_WIDTH-1:0]};
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inf_valid} - {1'b0, w_pop};
        end
    end

`ifdef GLB_RD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (w_accept)
            stall_cycles <= '0;
        else if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_glb_ifmap_reader.sv
// tb/tb_glb_ifmap_reader.sv - directed self-checking bench for glb_ifmap_reader
module tb_glb_ifmap_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done, busy;
    logic [31:0] mapping_param = '0, shape_param1 = '0, shape_param2 = '0, row_start = '0;
    logic [31:0] glb_ifmap_base_addr = '0;
    logic [31:0] glb_r_addr;
    logic [31:0] glb_r_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic [31:0] out_row, out_col, out_ch;
    logic        out_last;
`ifdef GLB_RD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int dcyc;

    glb_ifmap_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .mapping_param(mapping_param), .shape_param1(shape_param1),
        .shape_param2(shape_param2), .row_start(row_start),
        .glb_ifmap_base_addr(glb_ifmap_base_addr), .glb_r_addr(glb_r_addr),
        .glb_r_data(glb_r_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_ch(out_ch),
        .out_last(out_last)
`ifdef GLB_RD_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // GLB model: byte at address a holds a[7:0]^0x5A, upper lanes carry filler.
    always @(posedge clk) glb_r_data <= {8'hC3, 8'h3C, 8'hA5, glb_r_addr[7:0] ^ 8'h5A};

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] e_addr(input int j, input logic [31:0] base, input int w,
                                           input int ct, input logic [31:0] rs);
        logic [31:0] ch, col, row;
        ch  = j % ct;
        col = (j / ct) % w;
        row = rs + j / (ct * w);
        return base + (row * w + col) * ct + ch;
    endfunction

    function automatic logic [104:0] e_elem(input int j, input logic [31:0] base, input int w,
                                            input int ct, input logic [31:0] rs, input int n);
        logic [31:0] a;
        logic [31:0] ch, col, row;
        a   = e_addr(j, base, w, ct, rs);
        ch  = j % ct;
        col = (j / ct) % w;
        row = rs + j / (ct * w);
        return {a[7:0] ^ 8'h5A, row, col, ch, (j == n - 1)};
    endfunction

    task automatic run_tile(input string tag, input logic [31:0] mp, input logic [31:0] sp1,
                            input logic [31:0] sp2, input logic [31:0] rs,
                            input logic [31:0] base, input int n, input int w, input int ct,
                            input int mode, input int abort_at, input int mid_start,
                            output int done_cyc);
        int cyc, k, outstanding, issues, first_valid;
        logic prev_stall, iss, pop;
        logic [104:0] prev_v, cur_v;
        cyc = 0; k = 0; outstanding = 0; issues = 0; first_valid = 0;
        prev_stall = 1'b0; prev_v = '0;
        @(negedge clk);
        mapping_param = mp; shape_param1 = sp1; shape_param2 = sp2;
        row_start = rs; glb_ifmap_base_addr = base; start = 1'b1; out_ready = 1'b1;
        while (k < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (mid_start != 0 && cyc == mid_start);
            if (cyc == 1) begin
                mapping_param = 32'h0000_F1FF; shape_param1 = 32'h1FFF_FFFF;
                shape_param2 = 32'h0000_FF00; row_start = 32'd7; glb_ifmap_base_addr = 32'hDEAD_0000;
            end
            case (mode)
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       out_ready = !(cyc >= 3 && cyc <= 9);
                default: out_ready = 1'b1;
            endcase
            #1;
            cur_v = {out_data, out_row, out_col, out_ch, out_last};
            if (prev_stall) chk({tag, "_hold"}, cur_v, prev_v);
            if (out_valid && first_valid == 0) first_valid = cyc;
            iss = (glb_r_addr != 32'd0);
            pop = out_valid && out_ready;
            if (cyc == 1) chk({tag, "_first_addr"}, glb_r_addr, e_addr(0, base, w, ct, rs));
            if (iss) begin
                chk({tag, "_addr"}, glb_r_addr, e_addr(issues, base, w, ct, rs));
                chk({tag, "_outstanding"}, (outstanding + 1 - int'(pop)) <= 2, 1);
                issues++;
            end
            if (pop) begin
                chk({tag, "_elem"}, cur_v, e_elem(k, base, w, ct, rs, n));
                k++;
            end
            outstanding = outstanding + int'(iss) - int'(pop);
            prev_stall = out_valid && !out_ready;
            prev_v = cur_v;
            if (abort_at != 0 && k == abort_at) break;
        end
        done_cyc = cyc;
        if (abort_at == 0) begin
            chk({tag, "_count"}, k, n);
            chk({tag, "_first_valid_cycle"}, first_valid, 3);
            @(negedge clk);
            cyc++;
            #1;
            chk({tag, "_done"}, {done, busy, out_valid}, 3'b110);
            done_cyc = cyc;
            @(negedge clk);
            #1;
            chk({tag, "_idle"}, {done, busy, out_valid}, 3'b000);
        end
    endtask

    task automatic run_empty(input string tag);
        logic bad;
        bad = 1'b0;
        @(negedge clk);
        mapping_param = 32'h0000_0050; shape_param1 = 32'h01C0_0000; shape_param2 = 32'h0000_0400;
        row_start = '0; glb_ifmap_base_addr = 32'h100; start = 1'b1; out_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (glb_r_addr != 32'd0 || out_valid) bad = 1'b1;
`ifdef GLB_RD_PERF_EN
            if (c == 1) chk({tag, "_stall_cleared"}, stall_cycles, 0);
`endif
            chk({tag, "_done_c"}, done, (c == 2));
        end
        chk({tag, "_no_reads"}, bad, 0);
    endtask

    initial begin
        logic saw_done;
        #2;
        chk("reset_outputs", {glb_r_addr, out_valid, out_data, out_row, out_col, out_ch,
                              out_last, done, busy}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_idle", {busy, done, out_valid}, 3'b000);

        // Basic tile with a start pulse mid-tile.
        run_tile("basic", 32'h2050, 32'h01C0_0000, 32'h400, 0, 32'h100, 32, 4, 2, 0, 0, 10, dcyc);
        chk("basic_done_cycle", dcyc, 35);

        // Stride 2, pad 1: rows 2..6, W=5.
        run_tile("stride", 32'h2048, 32'h06C0_0000, 32'h300, 2, 32'h0, 25, 5, 1, 0, 0, 0, dcyc);
        chk("stride_done_cycle", dcyc, 28);

        run_tile("bp", 32'h2050, 32'h01C0_0000, 32'h400, 0, 32'h100, 32, 4, 2, 1, 0, 0, dcyc);

        run_empty("empty");

        // Reset after 10 outputs, then replay the tile.
        run_tile("rst", 32'h2050, 32'h01C0_0000, 32'h400, 0, 32'h100, 32, 4, 2, 0, 10, 0, dcyc);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {glb_r_addr, out_valid, out_data, out_row, out_col, out_ch,
                                out_last, done, busy}, '0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (done || busy || out_valid) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", saw_done, 0);
        run_tile("replay", 32'h2050, 32'h01C0_0000, 32'h400, 0, 32'h100, 32, 4, 2, 0, 0, 0, dcyc);
        chk("replay_done_cycle", dcyc, 35);

`ifdef GLB_RD_PERF_EN
        run_tile("perf", 32'h2050, 32'h01C0_0000, 32'h400, 0, 32'h100, 32, 4, 2, 2, 0, 0, dcyc);
        chk("perf_stall_at_done", stall_cycles, 7);
        run_empty("perf_next");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
